// File: rtl/sine_cmd_ctrl_if.sv
// UART byte-stream bundle between the UART RX/TX blocks and sine_cmd_ctrl.
// master: the UART side (drives received bytes, accepts responses).
// slave : the command controller (consumes received bytes, produces responses).
interface sine_cmd_ctrl_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_err;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output rx_valid, rx_data, rx_err, tx_ready,
        input  tx_data, tx_valid
    );

    modport slave (
        input  rx_valid, rx_data, rx_err, tx_ready,
        output tx_data, tx_valid
    );
endinterface

// File: rtl/sine_cmd_ctrl.sv
// UART command controller for the PWM sine generator.
// Parses 0xA5/ADDR/DATA frames, maintains the generator config registers and
// returns one ACK/NAK/read-data byte per frame.
// Optional macro SINE_CMD_CSUM_EN: adds a 4th CSUM byte (ADDR ^ DATA ^ 0xA5).
module sine_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 100000,
    parameter logic [15:0] PHASE_RST   = 16'h0100,
    parameter logic [7:0]  AMP_RST     = 8'hFF
) (
    input  logic              clk,
    input  logic              rst_n,
    sine_cmd_ctrl_if.slave    uart,
    output logic              cfg_enable,
    output logic [15:0]       cfg_phase_inc,
    output logic [7:0]        cfg_amplitude,
    output logic              cfg_update,
    output logic              busy
);

    localparam logic [7:0] SYNC = 8'hA5;
    localparam logic [7:0] ACK  = 8'h06;
    localparam logic [7:0] NAK  = 8'h15;
    localparam int unsigned TW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
`ifdef SINE_CMD_CSUM_EN
        S_CSUM,
`endif
        S_EXEC,
        S_RESP
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_addr, r_data;
`ifdef SINE_CMD_CSUM_EN
    logic [7:0]  r_csum;
`endif
    logic [TW-1:0] r_tmo_cnt;
    logic        r_enable;
    logic [7:0]  r_shadow;
    logic [15:0] r_phase;
    logic [7:0]  r_amp;
    logic        r_cfg_update;
    logic [2:0]  r_status;
    logic [7:0]  r_tx_data;
    logic        r_tx_valid;

    logic        w_rx_byte;
    logic        w_in_frame;
    logic        w_tmo;
    logic        w_exec;
    logic        w_ovr;
    logic        w_clr;
    logic        w_csum_ok;
    logic        w_valid;
    logic [6:0]  w_idx;
    logic        w_rd;
    logic [7:0]  w_rd_val;

    // rx_err takes priority over a coincident byte strobe
    assign w_rx_byte  = uart.rx_valid & ~uart.rx_err;
    assign w_in_frame = (r_state == S_ADDR) || (r_state == S_DATA)
`ifdef SINE_CMD_CSUM_EN
                        || (r_state == S_CSUM)
`endif
                        ;
    assign w_tmo  = w_in_frame && !uart.rx_valid && !uart.rx_err &&
                    (r_tmo_cnt == TW'(TIMEOUT_CYC - 1));
    assign w_exec = (r_state == S_EXEC) && !uart.rx_err;
    assign w_ovr  = w_rx_byte && ((r_state == S_EXEC) || (r_state == S_RESP));
    assign w_idx  = r_addr[6:0];
    assign w_rd   = r_addr[7];
`ifdef SINE_CMD_CSUM_EN
    assign w_csum_ok = (r_csum == (r_addr ^ r_data ^ SYNC));
`else
    assign w_csum_ok = 1'b1;
`endif
    assign w_valid = (w_idx <= 7'd4) && !(!w_rd && (w_idx == 7'd4)) && w_csum_ok;
    assign w_clr   = w_exec && w_valid && w_rd && (w_idx == 7'd4);

    // Read-back mux for the addressed register
    always_comb begin
        w_rd_val = '0;
        case (w_idx)
            7'd0:    w_rd_val = {7'b0, r_enable};
            7'd1:    w_rd_val = r_shadow;
            7'd2:    w_rd_val = r_phase[15:8];
            7'd3:    w_rd_val = r_amp;
            7'd4:    w_rd_val = {5'b0, r_status};
            default: w_rd_val = '0;
        endcase
    end

    // Frame parser next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_rx_byte && (uart.rx_data == SYNC)) w_state_nxt = S_ADDR;
            S_ADDR: if (w_rx_byte) w_state_nxt = S_DATA;
`ifdef SINE_CMD_CSUM_EN
            S_DATA: if (w_rx_byte) w_state_nxt = S_CSUM;
            S_CSUM: if (w_rx_byte) w_state_nxt = S_EXEC;
`else
            S_DATA: if (w_rx_byte) w_state_nxt = S_EXEC;
`endif
            S_EXEC: w_state_nxt = S_RESP;
            S_RESP: if (uart.tx_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_tmo) w_state_nxt = S_IDLE;
        if (uart.rx_err && (r_state != S_RESP)) w_state_nxt = S_IDLE;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Inter-byte timeout counter, restarted by every received byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          r_tmo_cnt <= '0;
        else if (w_in_frame && !uart.rx_valid) r_tmo_cnt <= r_tmo_cnt + 1'b1;
        else                                 r_tmo_cnt <= '0;
    end

    // Frame field capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_data <= '0;
`ifdef SINE_CMD_CSUM_EN
            r_csum <= '0;
`endif
        end else begin
            if ((r_state == S_ADDR) && w_rx_byte) r_addr <= uart.rx_data;
            if ((r_state == S_DATA) && w_rx_byte) r_data <= uart.rx_data;
`ifdef SINE_CMD_CSUM_EN
            if ((r_state == S_CSUM) && w_rx_byte) r_csum <= uart.rx_data;
`endif
        end
    end

    // Register file, response byte and handshake; all applied on the EXEC->RESP edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enable     <= 1'b0;
            r_shadow     <= '0;
            r_phase      <= PHASE_RST;
            r_amp        <= AMP_RST;
            r_cfg_update <= 1'b0;
            r_tx_data    <= '0;
            r_tx_valid   <= 1'b0;
        end else begin
            r_cfg_update <= 1'b0;
            if (w_exec) begin
                r_tx_valid <= 1'b1;
                if (!w_valid) begin
                    r_tx_data <= NAK;
                end else if (w_rd) begin
                    r_tx_data <= w_rd_val;
                end else begin
                    r_tx_data <= ACK;
                    case (w_idx)
                        7'd0: r_enable <= r_data[0];
                        7'd1: r_shadow <= r_data;
                        7'd2: begin
                            r_phase      <= {r_data, r_shadow};
                            r_cfg_update <= 1'b1;
                        end
                        7'd3: r_amp <= r_data;
                        default: ;
                    endcase
                end
            end else if ((r_state == S_RESP) && uart.tx_ready) begin
                r_tx_valid <= 1'b0;
            end
        end
    end

    // Sticky status; a flag raised in the clearing cycle survives the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_status <= '0;
        else        r_status <= (w_clr ? 3'b000 : r_status) | {uart.rx_err, w_tmo, w_ovr};
    end

    assign uart.tx_data  = r_tx_data;
    assign uart.tx_valid = r_tx_valid;
    assign cfg_enable    = r_enable;
    assign cfg_phase_inc = r_phase;
    assign cfg_amplitude = r_amp;
    assign cfg_update    = r_cfg_update;
    assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_sine_cmd_ctrl.sv
// Directed self-checking bench for sine_cmd_ctrl.
// Honours SINE_CMD_CSUM_EN: frames gain the CSUM byte and the checksum tests run.
module tb_sine_cmd_ctrl;

    localparam int unsigned TMO = 40;

    logic        clk;
    logic        rst_n;
    logic        cfg_enable;
    logic [15:0] cfg_phase_inc;
    logic [7:0]  cfg_amplitude;
    logic        cfg_update;
    logic        busy;

    int n_checks;
    int n_errors;
    int upd_cnt;

    sine_cmd_ctrl_if u_if ();

    sine_cmd_ctrl #(
        .TIMEOUT_CYC (TMO),
        .PHASE_RST   (16'h0100),
        .AMP_RST     (8'hFF)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .uart          (u_if.slave),
        .cfg_enable    (cfg_enable),
        .cfg_phase_inc (cfg_phase_inc),
        .cfg_amplitude (cfg_amplitude),
        .cfg_update    (cfg_update),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (cfg_update === 1'b1) upd_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] csum(input logic [7:0] a, input logic [7:0] d);
        return a ^ d ^ 8'hA5;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        u_if.rx_valid = 1'b1;
        u_if.rx_data  = b;
        @(negedge clk);
        u_if.rx_valid = 1'b0;
    endtask

    task automatic send_err();
        @(negedge clk);
        u_if.rx_err = 1'b1;
        @(negedge clk);
        u_if.rx_err = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
        send_byte(8'hA5);
        send_byte(a);
        send_byte(d);
`ifdef SINE_CMD_CSUM_EN
        send_byte(c);
`else
        if (c == 8'h00) begin end
`endif
    endtask

    // Sends a frame with tx_ready high and samples the response timeline
    task automatic run_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c,
                             output logic v_exec, output logic v_resp,
                             output logic [7:0] dat, output logic v_after);
        send_frame(a, d, c);
        v_exec = u_if.tx_valid;
        @(negedge clk);
        v_resp = u_if.tx_valid;
        dat    = u_if.tx_data;
        @(negedge clk);
        v_after = u_if.tx_valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        u_if.rx_valid = 1'b0;
        u_if.rx_data  = '0;
        u_if.rx_err   = 1'b0;
        u_if.tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (cfg_phase_inc !== 16'h0100) begin n_errors++; $display("FAIL reset_phase: got %h want 0100", cfg_phase_inc); end
        n_checks++; if (cfg_amplitude !== 8'hFF) begin n_errors++; $display("FAIL reset_amp: got %h want FF", cfg_amplitude); end
        n_checks++; if (cfg_enable !== 1'b0) begin n_errors++; $display("FAIL reset_enable: got %b want 0", cfg_enable); end
        n_checks++; if (u_if.tx_valid !== 1'b0) begin n_errors++; $display("FAIL reset_tx_valid: got %b want 0", u_if.tx_valid); end
        n_checks++; if (u_if.tx_data !== 8'h00) begin n_errors++; $display("FAIL reset_tx_data: got %h want 00", u_if.tx_data); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (cfg_update !== 1'b0) begin n_errors++; $display("FAIL reset_update: got %b want 0", cfg_update); end
    endtask

    task automatic test_amplitude();
        logic ve, vr, va;
        logic [7:0] dat;
        run_frame(8'h03, 8'h80, csum(8'h03, 8'h80), ve, vr, dat, va);
        n_checks++; if (ve !== 1'b0) begin n_errors++; $display("FAIL amp_latency_exec: tx_valid got %b want 0", ve); end
        n_checks++; if (vr !== 1'b1) begin n_errors++; $display("FAIL amp_latency_resp: tx_valid got %b want 1", vr); end
        n_checks++; if (dat !== 8'h06) begin n_errors++; $display("FAIL amp_ack: got %h want 06", dat); end
        n_checks++; if (va !== 1'b0) begin n_errors++; $display("FAIL amp_handshake_drop: tx_valid got %b want 0", va); end
        n_checks++; if (cfg_amplitude !== 8'h80) begin n_errors++; $display("FAIL amp_value: got %h want 80", cfg_amplitude); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL amp_busy_after: got %b want 0", busy); end
        run_frame(8'h83, 8'h00, csum(8'h83, 8'h00), ve, vr, dat, va);
        n_checks++; if (vr !== 1'b1 || dat !== 8'h80) begin n_errors++; $display("FAIL amp_read: valid %b data %h want 1/80", vr, dat); end
    endtask

    task automatic test_phase();
        logic ve, vr, va;
        logic [7:0] dat;
        int u0;
        u0 = upd_cnt;
        run_frame(8'h01, 8'h34, csum(8'h01, 8'h34), ve, vr, dat, va);
        n_checks++; if (dat !== 8'h06) begin n_errors++; $display("FAIL ph_lo_ack: got %h want 06", dat); end
        n_checks++; if (cfg_phase_inc !== 16'h0100) begin n_errors++; $display("FAIL ph_lo_no_commit: got %h want 0100", cfg_phase_inc); end
        n_checks++; if (upd_cnt !== u0) begin n_errors++; $display("FAIL ph_lo_no_update: pulses got %0d want %0d", upd_cnt - u0, 0); end
        run_frame(8'h02, 8'h12, csum(8'h02, 8'h12), ve, vr, dat, va);
        n_checks++; if (cfg_phase_inc !== 16'h1234) begin n_errors++; $display("FAIL ph_commit: got %h want 1234", cfg_phase_inc); end
        n_checks++; if (upd_cnt !== u0 + 1) begin n_errors++; $display("FAIL ph_update_pulse: pulses got %0d want 1", upd_cnt - u0); end
        run_frame(8'h81, 8'h00, csum(8'h81, 8'h00), ve, vr, dat, va);
        n_checks++; if (dat !== 8'h34) begin n_errors++; $display("FAIL ph_lo_read: got %h want 34", dat); end
        run_frame(8'h82, 8'h00, csum(8'h82, 8'h00), ve, vr, dat, va);
        n_checks++; if (dat !== 8'h12) begin n_errors++; $display("FAIL ph_hi_read: got %h want 12", dat); end
    endtask

    task automatic test_nak();
        logic ve, vr, va;
        logic [7:0] dat;
        logic seen;
        int u0;
        u0 = upd_cnt;
        run_frame(8'h07, 8'h55, csum(8'h07, 8'h55), ve, vr, dat, va);
        n_checks++; if (vr !== 1'b1 || dat !== 8'h15) begin n_errors++; $display("FAIL nak_bad_index: valid %b data %h want 1/15", vr, dat); end
        n_checks++; if (cfg_amplitude !== 8'h80 || cfg_phase_inc !== 16'h1234 || cfg_enable !== 1'b0)
            begin n_errors++; $display("FAIL nak_no_change: amp %h ph %h en %b want 80/1234/0", cfg_amplitude, cfg_phase_inc, cfg_enable); end
        run_frame(8'h04, 8'h07, csum(8'h04, 8'h07), ve, vr, dat, va);
        n_checks++; if (dat !== 8'h15) begin n_errors++; $display("FAIL nak_status_write: got %h want 15", dat); end
        n_checks++; if (upd_cnt !== u0) begin n_errors++; $display("FAIL nak_no_update: pulses got %0d want 0", upd_cnt - u0); end
        send_byte(8'h33);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (busy !== 1'b0 || u_if.tx_valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        n_checks++; if (seen !== 1'b0) begin n_errors++; $display("FAIL idle_junk_ignored: busy/tx activity got %b want 0", seen); end
    endtask

    task automatic test_timeout();
        logic ve, vr, va;
        logic [7:0] dat;
        logic seen;
        send_byte(8'hA5);
        send_byte(8'h03);
        seen = 1'b0;
        repeat (TMO - 1) begin
            @(negedge clk);
            if (u_if.tx_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL tmo_before_limit: busy got %b want 1", busy); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL tmo_at_limit: busy got %b want 0", busy); end
        repeat (3) begin
            @(negedge clk);
            if (u_if.tx_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_errors++; $display("FAIL tmo_no_response: tx_valid seen %b want 0", seen); end
        run_frame(8'h84, 8'h00, csum(8'h84, 8'h00), ve, vr, dat, va);
        n_checks++; if (dat !== 8'h02) begin n_errors++; $display("FAIL tmo_status: got %h want 02", dat); end
        run_frame(8'h84, 8'h00, csum(8'h84, 8'h00), ve, vr, dat, va);
        n_checks++; if (dat !== 8'h00) begin n_errors++; $display("FAIL status_cleared: got %h want 00", dat); end
    endtask

    task automatic test_ctrl();
        logic ve, vr, va;
        logic [7:0] dat;
        run_frame(8'h00, 8'hFF, csum(8'h00, 8'hFF), ve, vr, dat, va);
        n_checks++; if (cfg_enable !== 1'b1) begin n_errors++; $display("FAIL ctrl_enable: got %b want 1", cfg_enable); end
        run_frame(8'h80, 8'h00, csum(8'h80, 8'h00), ve, vr, dat, va);
        n_checks++; if (dat !== 8'h01) begin n_errors++; $display("FAIL ctrl_read: got %h want 01", dat); end
    endtask

    task automatic test_overrun_hold();
        logic ve, vr, va;
        logic [7:0] dat;
        logic bad;
        u_if.tx_ready = 1'b0;
        send_frame(8'h03, 8'h22, csum(8'h03, 8'h22));
        @(negedge clk);
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (u_if.tx_valid !== 1'b1 || u_if.tx_data !== 8'h06) bad = 1'b1;
            if (i == 1) send_byte(8'hA5);
            else @(negedge clk);
        end
        n_checks++; if (bad !== 1'b0) begin n_errors++; $display("FAIL hold_stable: tx_valid %b data %h want 1/06", u_if.tx_valid, u_if.tx_data); end
        u_if.tx_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (u_if.tx_valid !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL hold_release: tx_valid %b busy %b want 0/0", u_if.tx_valid, busy); end
        n_checks++; if (cfg_amplitude !== 8'h22) begin n_errors++; $display("FAIL hold_amp: got %h want 22", cfg_amplitude); end
        run_frame(8'h84, 8'h00, csum(8'h84, 8'h00), ve, vr, dat, va);
        n_checks++; if (dat !== 8'h01) begin n_errors++; $display("FAIL overrun_status: got %h want 01", dat); end
    endtask

    task automatic test_rx_err();
        logic ve, vr, va;
        logic [7:0] dat;
        send_byte(8'hA5);
        send_byte(8'h03);
        send_err();
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rxerr_abort: busy got %b want 0", busy); end
        n_checks++; if (cfg_amplitude !== 8'h22) begin n_errors++; $display("FAIL rxerr_no_write: amp got %h want 22", cfg_amplitude); end
        run_frame(8'h84, 8'h00, csum(8'h84, 8'h00), ve, vr, dat, va);
        n_checks++; if (dat !== 8'h04) begin n_errors++; $display("FAIL rxerr_status: got %h want 04", dat); end
        u_if.tx_ready = 1'b0;
        send_frame(8'h03, 8'h55, csum(8'h03, 8'h55));
        @(negedge clk);
        send_err();
        n_checks++; if (u_if.tx_valid !== 1'b1 || u_if.tx_data !== 8'h06) begin n_errors++; $display("FAIL rxerr_in_resp: tx_valid %b data %h want 1/06", u_if.tx_valid, u_if.tx_data); end
        u_if.tx_ready = 1'b1;
        @(negedge clk);
        run_frame(8'h84, 8'h00, csum(8'h84, 8'h00), ve, vr, dat, va);
        n_checks++; if (dat !== 8'h04) begin n_errors++; $display("FAIL rxerr_resp_flag: got %h want 04", dat); end
    endtask

`ifdef SINE_CMD_CSUM_EN
    task automatic test_csum();
        logic ve, vr, va;
        logic [7:0] dat;
        run_frame(8'h03, 8'h40, 8'hE6, ve, vr, dat, va);
        n_checks++; if (dat !== 8'h06 || cfg_amplitude !== 8'h40) begin n_errors++; $display("FAIL csum_good: resp %h amp %h want 06/40", dat, cfg_amplitude); end
        run_frame(8'h03, 8'h11, 8'h00, ve, vr, dat, va);
        n_checks++; if (dat !== 8'h15 || cfg_amplitude !== 8'h40) begin n_errors++; $display("FAIL csum_bad: resp %h amp %h want 15/40", dat, cfg_amplitude); end
        run_frame(8'h83, 8'h00, 8'h00, ve, vr, dat, va);
        n_checks++; if (dat !== 8'h15) begin n_errors++; $display("FAIL csum_bad_read: resp %h want 15", dat); end
    endtask
`endif

    task automatic test_async_reset();
        u_if.tx_ready = 1'b0;
        send_frame(8'h03, 8'h10, csum(8'h03, 8'h10));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (u_if.tx_valid !== 1'b0 || busy !== 1'b0 || cfg_amplitude !== 8'hFF || cfg_phase_inc !== 16'h0100)
            begin n_errors++; $display("FAIL async_reset: tx_valid %b busy %b amp %h ph %h want 0/0/FF/0100", u_if.tx_valid, busy, cfg_amplitude, cfg_phase_inc); end
        @(negedge clk);
        rst_n = 1'b1;
        u_if.tx_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        upd_cnt  = 0;
        test_reset();
        test_amplitude();
        test_phase();
        test_nak();
        test_timeout();
        test_ctrl();
        test_overrun_hold();
        test_rx_err();
`ifdef SINE_CMD_CSUM_EN
        test_csum();
`endif
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
